// File: rtl/pipe_reg_skid.sv
// Pipeline stage register: NLANE x DATA_W payload, valid/ready with a 2-entry skid buffer.
// Optional performance counters (stall_cnt, flush_cnt) are enabled by defining PIPE_REG_SKID_PERF_EN.
module pipe_reg_skid #(
  parameter int DATA_W = 32,
  parameter int NLANE  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NLANE*DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NLANE*DATA_W-1:0] out_data
`ifdef PIPE_REG_SKID_PERF_EN
  ,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        flush_cnt
`endif
);

  localparam int PW = NLANE * DATA_W;

  if (DATA_W < 1 || NLANE < 1 || CNT_W < 1) begin : g_bad_param
    $error("pipe_reg_skid: DATA_W, NLANE and CNT_W must be positive");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   m_q, m_d;
  logic [PW-1:0]   s_q, s_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            accept, send;

  assign accept    = in_valid & in_ready_q;
  assign send      = out_valid_q & out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = m_q;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    if (flush) begin
      // A send this cycle still completes; any accept is silently dropped.
      state_d = EMPTY;
      m_d     = '0;
      s_d     = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            m_d     = in_data;
          end
        end
        ONE: begin
          if (accept && send) begin
            m_d = in_data;
          end else if (accept) begin
            state_d = TWO;
            s_d     = in_data;
          end else if (send) begin
            state_d = EMPTY;
            m_d     = '0;
          end
        end
        TWO: begin
          if (send) begin
            state_d = ONE;
            m_d     = s_q;
            s_d     = '0;
          end
        end
        default: begin
          state_d = EMPTY;
          m_d     = '0;
          s_d     = '0;
        end
      endcase
    end
    // Handshake flags are registered copies of the next occupancy, so out_ready never reaches in_ready combinationally.
    in_ready_d  = (state_d != TWO);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      m_q         <= '0;
      s_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      s_q         <= s_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef PIPE_REG_SKID_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid_q && !out_ready) stall_cnt_d = sat_inc(stall_cnt_q);
    if (flush && (state_q != EMPTY)) flush_cnt_d = sat_inc(flush_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Scoreboard bench for pipe_reg_skid: driver queues expected payloads, a negedge monitor checks every transfer.
module tb_pipe_reg_skid;
  localparam int DATA_W = 32;
  localparam int NLANE  = 8;
  localparam int CNT_W  = 4;
  localparam int PW     = DATA_W * NLANE;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [PW-1:0] in_data, out_data;
`ifdef PIPE_REG_SKID_PERF_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [PW-1:0] exp_q[$];

  pipe_reg_skid #(.DATA_W(DATA_W), .NLANE(NLANE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef PIPE_REG_SKID_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Value v in lane 0 and its inverse in the top lane, so lane placement is exercised too.
  function automatic logic [PW-1:0] mk(input logic [DATA_W-1:0] v);
    logic [PW-1:0] r;
    r = '0;
    r[0 +: DATA_W] = v;
    r[(NLANE-1)*DATA_W +: DATA_W] = ~v;
    return r;
  endfunction

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a transfer happens at the next rising edge whenever out_valid & out_ready at negedge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL mon_unexpected: got %h expected no transfer", out_data);
      end else begin
        if (out_data !== exp_q[0]) begin
          errors++;
          $display("FAIL mon_data: got %h expected %h", out_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = mk(32'h9); out_ready = 1'b0;
    tick(); tick();
    chk("rst_out_valid", PW'(out_valid), PW'(1'b0));
    chk("rst_out_data", out_data, '0);
    chk("rst_in_ready", PW'(in_ready), PW'(1'b1));
    rst = 1'b0; in_valid = 1'b0;
    tick();
    chk("rst_nothing_held", PW'(out_valid), PW'(1'b0));

    // Streaming at full throughput
    out_ready = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      in_valid = 1'b1; in_data = mk(DATA_W'(v)); exp_q.push_back(mk(DATA_W'(v)));
      chk("stream_in_ready", PW'(in_ready), PW'(1'b1));
      tick();
      chk("stream_out_valid", PW'(out_valid), PW'(1'b1));
      chk("stream_out_data", out_data, mk(DATA_W'(v)));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drained", PW'(out_valid), PW'(1'b0));
    chk("stream_drained_data", out_data, '0);

    // Back-pressure fills the skid register
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = mk(32'hA); exp_q.push_back(mk(32'hA));
    tick();
    chk("bp_ready_one", PW'(in_ready), PW'(1'b1));
    in_data = mk(32'hB); exp_q.push_back(mk(32'hB));
    tick();
    chk("bp_ready_two", PW'(in_ready), PW'(1'b0));
    chk("bp_head", out_data, mk(32'hA));
    in_data = mk(32'hC);
    tick();
    chk("bp_held_off", PW'(in_ready), PW'(1'b0));
    chk("bp_stable", out_data, mk(32'hA));
    out_ready = 1'b1; exp_q.push_back(mk(32'hC));
    tick();
    chk("bp_skid_moved", out_data, mk(32'hB));
    chk("bp_ready_back", PW'(in_ready), PW'(1'b1));
    tick();
    chk("bp_third", out_data, mk(32'hC));
    in_valid = 1'b0;
    tick();
    chk("bp_empty_valid", PW'(out_valid), PW'(1'b0));
    chk("bp_empty_data", out_data, '0);

    // Flush from TWO drops everything, including a presented item
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = mk(32'h5);
    tick();
    in_data = mk(32'h6);
    tick();
    chk("fl_two", PW'(in_ready), PW'(1'b0));
    flush = 1'b1; in_data = mk(32'h7);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", PW'(out_valid), PW'(1'b0));
    chk("fl_data", out_data, '0);
    chk("fl_ready", PW'(in_ready), PW'(1'b1));
    tick();
    chk("fl_stays_empty", PW'(out_valid), PW'(1'b0));

    // Flush in ONE: concurrent send completes, concurrent accept is dropped
    in_valid = 1'b1; in_data = mk(32'h8); exp_q.push_back(mk(32'h8));
    tick();
    flush = 1'b1; in_data = mk(32'h9); out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl1_valid", PW'(out_valid), PW'(1'b0));
    chk("fl1_data", out_data, '0);

    // Reset and flush together while in ONE
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = mk(32'h11);
    tick();
    in_valid = 1'b0; rst = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0;
    chk("rf_valid", PW'(out_valid), PW'(1'b0));
    chk("rf_data", out_data, '0);
    chk("rf_ready", PW'(in_ready), PW'(1'b1));
`ifdef PIPE_REG_SKID_PERF_EN
    chk("rf_flush_cnt", PW'(flush_cnt), PW'(0));
    chk("rf_stall_cnt", PW'(stall_cnt), PW'(0));
`endif

    // Single held entry under back-pressure, then drain
    in_valid = 1'b1; in_data = mk(32'hD); exp_q.push_back(mk(32'hD));
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
`ifdef PIPE_REG_SKID_PERF_EN
    chk("stall_10", PW'(stall_cnt), PW'(10));
`endif
    repeat (10) tick();
    chk("hold_stable", out_data, mk(32'hD));
`ifdef PIPE_REG_SKID_PERF_EN
    chk("stall_sat", PW'(stall_cnt), PW'(15));
`endif
    out_ready = 1'b1;
    repeat (3) tick();
    chk("final_empty", PW'(out_valid), PW'(1'b0));
    chk("scoreboard_drained", PW'(exp_q.size()), PW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
